fetch_unit: RTL and testbench

Instruction-fetch stage of the 5-stage MIPS pipeline, directly upstream of decode. It owns the PC register and issues word requests to instruction memory over a req/ack handshake that tolerates wait states. It also owns the IF/ID pipeline register that feeds the decode stage, including hazard stalls and redirect/flush when a branch resolves in ID.

---
 rtl/mips_pkg.sv | 15 +
 rtl/if_id_pipe_reg.sv | 62 ++++++
 rtl/fetch_unit.sv | 132 +++++++++++++
 tb/tb_fetch_unit.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared types and constants for the MIPS pipeline front end.
package mips_pkg;

   localparam int                  PC_WIDTH          = 32;
   localparam logic [PC_WIDTH-1:0] PC_INC            = 32'd4;
   localparam logic [31:0]         NOP_INSTR_DEFAULT = 32'h0000_0000;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      DROP = 2'd2,
      BUF  = 2'd3
   } fetchStateT;

endpackage

// File: rtl/if_id_pipe_reg.sv
// IF/ID pipeline register with load/hold/flush/bubble controls and a one-entry
// skid buffer that catches an instruction arriving while decode is stalled.
module if_id_pipe_reg
   import mips_pkg::*;
#(
   parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                flush,
   input  logic                load,
   input  logic                loadBuf,
   input  logic                bubble,
   input  logic                bufWrite,
   input  logic                bufClear,
   input  logic [PC_WIDTH-1:0] pcPlus4In,
   input  logic [31:0]         instrIn,
   output logic [PC_WIDTH-1:0] pcPlus4,
   output logic [31:0]         instr,
   output logic                valid
);

   logic [PC_WIDTH-1:0] bufPcPlus4;
   logic [31:0]         bufInstr;

   // Priority: flush beats every load; no control asserted means hold (stall).
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pcPlus4 <= '0;
         instr   <= NOP_INSTR;
         valid   <= 1'b0;
      end else if (flush) begin
         instr <= NOP_INSTR;
         valid <= 1'b0;
      end else if (load) begin
         pcPlus4 <= pcPlus4In;
         instr   <= instrIn;
         valid   <= 1'b1;
      end else if (loadBuf) begin
         pcPlus4 <= bufPcPlus4;
         instr   <= bufInstr;
         valid   <= 1'b1;
      end else if (bubble) begin
         instr <= NOP_INSTR;
         valid <= 1'b0;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         bufPcPlus4 <= '0;
         bufInstr   <= '0;
      end else if (bufClear) begin
         bufPcPlus4 <= '0;
         bufInstr   <= '0;
      end else if (bufWrite) begin
         bufPcPlus4 <= pcPlus4In;
         bufInstr   <= instrIn;
      end
   end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC register, instruction memory req/ack FSM and
// IF/ID register control including hazard stalls and branch redirects from ID.
module fetch_unit
   import mips_pkg::*;
#(
   parameter logic [PC_WIDTH-1:0] RESET_PC  = 32'h0000_0000,
   parameter logic [31:0]         NOP_INSTR = NOP_INSTR_DEFAULT
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                stall,
   input  logic                branch_taken,
   input  logic [PC_WIDTH-1:0] branch_target,
   output logic                imem_req,
   output logic [PC_WIDTH-1:0] imem_addr,
   input  logic                imem_ack,
   input  logic [31:0]         imem_rdata,
   output logic [PC_WIDTH-1:0] pc_if,
   output logic [PC_WIDTH-1:0] pc_plus4_id,
   output logic [31:0]         instruction_id,
   output logic                valid_id,
   output fetchStateT          dbgState
);

   fetchStateT          state, stateNext;
   logic [PC_WIDTH-1:0] pc, pcNext, reqAddr, reqAddrNext, pcPlus4;
   logic                redirect, ackTaken;
   logic                flush, load, loadBuf, bubble, bufWrite, bufClear;

   // Handshake: a request is open while imem_req=1 with imem_addr held stable;
   // it completes at the edge where imem_req=1 and imem_ack=1 (no-wait ack legal).
   assign imem_req  = (state == REQ) || (state == DROP);
   assign imem_addr = reqAddr;
   assign pc_if     = pc;
   assign dbgState  = state;
   assign pcPlus4   = pc + PC_INC;
   assign ackTaken  = imem_req && imem_ack;
   assign redirect  = branch_taken && !stall;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state   <= IDLE;
         pc      <= RESET_PC;
         reqAddr <= RESET_PC;
      end else begin
         state   <= stateNext;
         pc      <= pcNext;
         reqAddr <= reqAddrNext;
      end
   end

   always_comb begin
      stateNext   = state;
      pcNext      = pc;
      reqAddrNext = reqAddr;
      flush       = 1'b0;
      load        = 1'b0;
      loadBuf     = 1'b0;
      bubble      = 1'b0;
      bufWrite    = 1'b0;
      bufClear    = 1'b0;
      if (redirect) begin
         pcNext   = branch_target;
         flush    = 1'b1;
         bufClear = 1'b1;
         // An unanswered request must still complete before the target is fetched.
         if (imem_req && !imem_ack) begin
            stateNext = DROP;
         end else begin
            stateNext   = REQ;
            reqAddrNext = branch_target;
         end
      end else begin
         case (state)
            IDLE: begin
               stateNext   = REQ;
               reqAddrNext = pc;
               bubble      = !stall;
            end
            REQ: begin
               if (ackTaken) begin
                  pcNext      = pcPlus4;
                  reqAddrNext = pcPlus4;
                  if (stall) begin
                     bufWrite  = 1'b1;
                     stateNext = BUF;
                  end else begin
                     load = 1'b1;
                  end
               end else begin
                  bubble = !stall;
               end
            end
            DROP: begin
               bubble = !stall;
               if (ackTaken) begin
                  stateNext   = REQ;
                  reqAddrNext = pc;
               end
            end
            BUF: begin
               if (!stall) begin
                  loadBuf     = 1'b1;
                  bufClear    = 1'b1;
                  stateNext   = REQ;
                  reqAddrNext = pc;
               end
            end
            default: stateNext = IDLE;
         endcase
      end
   end

   if_id_pipe_reg #(
      .NOP_INSTR (NOP_INSTR)
   ) ifIdReg (
      .clk       (clk),
      .reset     (reset),
      .flush     (flush),
      .load      (load),
      .loadBuf   (loadBuf),
      .bubble    (bubble),
      .bufWrite  (bufWrite),
      .bufClear  (bufClear),
      .pcPlus4In (pcPlus4),
      .instrIn   (imem_rdata),
      .pcPlus4   (pc_plus4_id),
      .instr     (instruction_id),
      .valid     (valid_id)
   );

endmodule

// File: tb/tb_fetch_unit.sv
// Randomized bench for fetch_unit: a wait-state memory, a transaction-level fetch
// model feeding an expected queue, and a monitor checking every IF/ID delivery.
module tb_fetch_unit;
   import mips_pkg::*;

   localparam logic [31:0] RESET_PC = 32'h0000_0000;
   localparam logic [31:0] NOP      = 32'h0000_0000;

   logic        clk, reset, stall, branch_taken, imem_req, imem_ack, valid_id;
   logic [31:0] branch_target, imem_addr, imem_rdata, pc_if, pc_plus4_id, instruction_id;
   fetchStateT  dbgState;

   int          nCompared, nMismatched;
   int          stallPct, brPct, latMin, latMax;
   logic        running, modelGo;
   logic [31:0] expPc;
   logic [63:0] exp_q[$];

   fetch_unit #(
      .RESET_PC  (RESET_PC),
      .NOP_INSTR (NOP)
   ) dut (
      .clk            (clk),
      .reset          (reset),
      .stall          (stall),
      .branch_taken   (branch_taken),
      .branch_target  (branch_target),
      .imem_req       (imem_req),
      .imem_addr      (imem_addr),
      .imem_ack       (imem_ack),
      .imem_rdata     (imem_rdata),
      .pc_if          (pc_if),
      .pc_plus4_id    (pc_plus4_id),
      .instruction_id (instruction_id),
      .valid_id       (valid_id),
      .dbgState       (dbgState)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      nCompared++;
      if (act !== exp) begin
         nMismatched++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] memData(input logic [31:0] a);
      return a ^ 32'hA5A5_0000;
   endfunction

   // Driver + reference model. The model only knows program order: fetches walk
   // PC by 4, a taken unstalled branch kills everything fetched but not yet in
   // IF/ID (including an answer still in flight) and restarts at the target.
   initial begin : driver
      int          waitCnt;
      logic        ackV, stallV, brV, ackTakenV, redirectV, prevWaiting, dropPending;
      logic [31:0] tgt, rdataV, prevAddr, r;
      waitCnt     = 0;
      prevWaiting = 1'b0;
      dropPending = 1'b0;
      prevAddr    = '0;
      wait (modelGo);
      forever begin
         @(negedge clk);
         if (!running) break;
         chk("pc_if", 64'(pc_if), 64'(expPc));
         if (imem_req) begin
            if (waitCnt == 0) begin
               ackV    = 1'b1;
               waitCnt = $urandom_range(latMax, latMin);
            end else begin
               ackV    = 1'b0;
               waitCnt = waitCnt - 1;
            end
         end else begin
            ackV = 1'b0;
         end
         stallV = ($urandom_range(0, 99) < stallPct);
         brV    = ($urandom_range(0, 99) < brPct);
         r      = $urandom;
         case ($urandom_range(0, 3))
            0:       tgt = 32'hFFFF_FFF8;
            1:       tgt = r;
            2:       tgt = r & 32'h0000_00FC;
            default: tgt = r & 32'hFFFF_FFFC;
         endcase
         rdataV        = ackV ? memData(imem_addr) : $urandom;
         stall         = stallV;
         branch_taken  = brV;
         branch_target = tgt;
         imem_ack      = ackV;
         imem_rdata    = rdataV;

         ackTakenV = imem_req && ackV;
         redirectV = brV && !stallV;
         if (imem_req && prevWaiting) chk("addr_stable", 64'(imem_addr), 64'(prevAddr));
         prevWaiting = imem_req && !ackV;
         prevAddr    = imem_addr;
         if (ackTakenV && !dropPending) chk("fetch_addr", 64'(imem_addr), 64'(expPc));
         if (redirectV) begin
            exp_q.delete();
            expPc       = tgt;
            dropPending = imem_req && !ackV;
         end else if (ackTakenV) begin
            if (dropPending) begin
               dropPending = 1'b0;
            end else begin
               exp_q.push_back({expPc + 32'd4, rdataV});
               expPc = expPc + 32'd4;
            end
         end
      end
   end

   // Monitor: an unstalled edge either delivers the next expected instruction
   // (valid_id=1) or leaves nothing pending; a stalled edge holds IF/ID.
   initial begin : monitor
      logic [63:0] snapId, e;
      logic        snapValid, edgeStall;
      wait (modelGo);
      forever begin
         @(negedge clk);
         #2;
         if (!running) break;
         snapId    = {pc_plus4_id, instruction_id};
         snapValid = valid_id;
         edgeStall = stall;
         @(posedge clk);
         #1;
         if (edgeStall) begin
            chk("stall_hold_id", {pc_plus4_id, instruction_id}, snapId);
            chk("stall_hold_valid", 64'(valid_id), 64'(snapValid));
         end else if (valid_id) begin
            if (exp_q.size() == 0) begin
               nCompared++;
               nMismatched++;
               $display("FAIL unexpected_instr: got %h/%h with nothing expected", pc_plus4_id, instruction_id);
            end else begin
               e = exp_q.pop_front();
               chk("if_id_pc_plus4", 64'(pc_plus4_id), 64'(e[63:32]));
               chk("if_id_instr", 64'(instruction_id), 64'(e[31:0]));
            end
         end else begin
            chk("missing_instr", 64'(exp_q.size()), 64'd0);
         end
      end
   end

   initial begin : main
      reset         = 1'b0;
      stall         = 1'b0;
      branch_taken  = 1'b0;
      branch_target = '0;
      imem_ack      = 1'b0;
      imem_rdata    = '0;
      nCompared     = 0;
      nMismatched   = 0;
      running       = 1'b0;
      modelGo       = 1'b0;
      expPc         = RESET_PC;
      stallPct      = 0;
      brPct         = 0;
      latMin        = 0;
      latMax        = 0;

      repeat (3) @(posedge clk);
      #1;
      chk("reset_pc_if", 64'(pc_if), 64'(RESET_PC));
      chk("reset_imem_req", 64'(imem_req), 64'd0);
      chk("reset_imem_addr", 64'(imem_addr), 64'(RESET_PC));
      chk("reset_valid_id", 64'(valid_id), 64'd0);
      chk("reset_instr_id", 64'(instruction_id), 64'(NOP));
      chk("reset_pc_plus4_id", 64'(pc_plus4_id), 64'd0);

      @(negedge clk);
      reset   = 1'b1;
      running = 1'b1;
      modelGo = 1'b1;
      #1;
      chk("first_req_delay", 64'(imem_req), 64'd0);
      @(posedge clk);
      #1;
      chk("first_req", 64'(imem_req), 64'd1);
      chk("first_addr", 64'(imem_addr), 64'(RESET_PC));

      // zero-wait streaming, then fixed two-cycle waits, then random mixes
      repeat (12) @(posedge clk);
      latMin = 2; latMax = 2;
      repeat (15) @(posedge clk);
      latMin = 0; latMax = 3; stallPct = 25; brPct = 10;
      repeat (3000) @(posedge clk);
      latMin = 0; latMax = 1; stallPct = 50; brPct = 25;
      repeat (1500) @(posedge clk);
      running = 1'b0;
      repeat (3) @(posedge clk);
      stall        = 1'b0;
      branch_taken = 1'b0;
      imem_ack     = 1'b0;
      repeat (4) @(posedge clk);

      // asynchronous reset between edges
      #3;
      reset = 1'b0;
      #1;
      chk("async_reset_imem_req", 64'(imem_req), 64'd0);
      chk("async_reset_pc_if", 64'(pc_if), 64'(RESET_PC));
      chk("async_reset_valid_id", 64'(valid_id), 64'd0);
      chk("async_reset_instr_id", 64'(instruction_id), 64'(NOP));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
      $finish;
   end

endmodule
